// File: rtl/hamming_pkg.sv
// Shared constants, types and bit-placement helpers for the Hamming(15,11) scheduler.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hamming_pkg;

  localparam int DATA_W = 11;
  localparam int CW_W   = 15;
  localparam int SYN_W  = 4;

  // Parity bits live at Hamming positions 1, 2, 4 and 8 (cw index = position - 1).
  localparam int PAR0_POS = 0;
  localparam int PAR1_POS = 1;
  localparam int PAR2_POS = 3;
  localparam int PAR3_POS = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENC_RSP = 2'd1,
    DEC_RSP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_ENC = 1'b0,
    GNT_DEC = 1'b1
  } grant_e;

  function automatic logic is_par_pos(input int idx);
    return (idx == PAR0_POS) || (idx == PAR1_POS) || (idx == PAR2_POS) || (idx == PAR3_POS);
  endfunction

  // Scatter data bits into the non-parity slots in ascending order; parity slots stay 0.
  function automatic logic [CW_W-1:0] place_data(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    int j;
    cw = '0;
    j  = 0;
    for (int i = 0; i < CW_W; i++) begin
      if (!is_par_pos(i)) begin
        cw[i] = d[j];
        j++;
      end
    end
    return cw;
  endfunction

  // Gather the data bits back out of the non-parity slots.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 0; i < CW_W; i++) begin
      if (!is_par_pos(i)) begin
        d[j] = cw[i];
        j++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_core.sv
// Combinational Hamming(15,11) core: one syndrome tree serves both encode and decode.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller muxes its input and registers the outputs.
module hamming_core
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]   cw_i,
  output logic [SYN_W-1:0]  syn_o,
  output logic              corr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CW_W-1:0]   enc_cw_o
);

  logic [CW_W-1:0] flip;
  logic [CW_W-1:0] one_hot;

  // Syndrome is the XOR of the positions of all set bits. For an encode the input
  // carries data with zeroed parity slots, so the syndrome is exactly the parity to insert.
  always_comb begin
    syn_o = '0;
    for (int i = 0; i < CW_W; i++) begin
      if (cw_i[i]) syn_o = syn_o ^ SYN_W'(i + 1);
    end
  end

  // Correct the single bit named by a nonzero syndrome, then pull the data out.
  always_comb begin
    one_hot  = CW_W'(1);
    flip     = '0;
    corr_o   = (syn_o != '0);
    if (corr_o) flip = one_hot << (syn_o - SYN_W'(1));
    data_o   = extract_data(cw_i ^ flip);
    enc_cw_o = cw_i;
    enc_cw_o[PAR0_POS] = syn_o[0];
    enc_cw_o[PAR1_POS] = syn_o[1];
    enc_cw_o[PAR2_POS] = syn_o[2];
    enc_cw_o[PAR3_POS] = syn_o[3];
  end

endmodule

// File: rtl/hamming_arb.sv
// Round-robin scheduler sharing one Hamming core between encode and decode requesters.
// Latency: result registered on the accept edge; one op in flight, 1 op per 2 cycles peak.
// Backpressure: response held until rsp_ready; request ready only in IDLE. HAMMING_ERRCNT_EN enables err_cnt.
module hamming_arb
  import hamming_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enc_valid,
  output logic              enc_ready,
  input  logic [DATA_W-1:0] enc_data,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [CW_W-1:0]   dec_cw,
  output logic              enc_rsp_valid,
  input  logic              enc_rsp_ready,
  output logic [CW_W-1:0]   enc_rsp_cw,
  output logic              dec_rsp_valid,
  input  logic              dec_rsp_ready,
  output logic [DATA_W-1:0] dec_rsp_data,
  output logic [SYN_W-1:0]  dec_rsp_syn,
  output logic              dec_rsp_corr,
  input  logic              err_clr,
  output logic [7:0]        err_cnt
);

  state_e            state_q;
  grant_e            last_grant_q;
  logic              enc_rsp_valid_q;
  logic              dec_rsp_valid_q;
  logic [CW_W-1:0]   enc_rsp_cw_q;
  logic [DATA_W-1:0] dec_rsp_data_q;
  logic [SYN_W-1:0]  dec_rsp_syn_q;
  logic              dec_rsp_corr_q;

  logic              sel_enc;
  logic              enc_acc;
  logic              dec_acc;
  logic [CW_W-1:0]   core_cw;
  logic [SYN_W-1:0]  core_syn;
  logic              core_corr;
  logic [DATA_W-1:0] core_data;
  logic [CW_W-1:0]   core_enc_cw;

  // Grant encode when it is alone or when decode won the previous accepted request.
  always_comb begin
    sel_enc   = enc_valid && (!dec_valid || (last_grant_q == GNT_DEC));
    enc_ready = (state_q == IDLE) && sel_enc;
    dec_ready = (state_q == IDLE) && dec_valid && !sel_enc;
    enc_acc   = enc_valid && enc_ready;
    dec_acc   = dec_valid && dec_ready;
    core_cw   = sel_enc ? place_data(enc_data) : dec_cw;
  end

  hamming_core u_core (
    .cw_i     (core_cw),
    .syn_o    (core_syn),
    .corr_o   (core_corr),
    .data_o   (core_data),
    .enc_cw_o (core_enc_cw)
  );

  // Control FSM: latch the core result on accept, hold it until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      last_grant_q    <= GNT_DEC;
      enc_rsp_valid_q <= 1'b0;
      dec_rsp_valid_q <= 1'b0;
      enc_rsp_cw_q    <= '0;
      dec_rsp_data_q  <= '0;
      dec_rsp_syn_q   <= '0;
      dec_rsp_corr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enc_acc) begin
            state_q         <= ENC_RSP;
            last_grant_q    <= GNT_ENC;
            enc_rsp_valid_q <= 1'b1;
            enc_rsp_cw_q    <= core_enc_cw;
          end else if (dec_acc) begin
            state_q         <= DEC_RSP;
            last_grant_q    <= GNT_DEC;
            dec_rsp_valid_q <= 1'b1;
            dec_rsp_data_q  <= core_data;
            dec_rsp_syn_q   <= core_syn;
            dec_rsp_corr_q  <= core_corr;
          end
        end
        ENC_RSP: begin
          if (enc_rsp_ready) begin
            state_q         <= IDLE;
            enc_rsp_valid_q <= 1'b0;
          end
        end
        DEC_RSP: begin
          if (dec_rsp_ready) begin
            state_q         <= IDLE;
            dec_rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q         <= IDLE;
          enc_rsp_valid_q <= 1'b0;
          dec_rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign enc_rsp_valid = enc_rsp_valid_q;
  assign enc_rsp_cw    = enc_rsp_cw_q;
  assign dec_rsp_valid = dec_rsp_valid_q;
  assign dec_rsp_data  = dec_rsp_data_q;
  assign dec_rsp_syn   = dec_rsp_syn_q;
  assign dec_rsp_corr  = dec_rsp_corr_q;

`ifdef HAMMING_ERRCNT_EN
  logic [7:0] err_cnt_q;
  logic [7:0] err_cnt_d;

  // Clear wins over a same-edge increment; count saturates instead of wrapping.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = 8'h00;
    end else if (dec_acc && core_corr && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'h01;
    end
  end

  // Corrected-word counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'h00;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = 8'h00;
`endif

endmodule

// File: tb/tb_hamming_arb.sv
// Directed self-checking bench for hamming_arb.
// Latency: checks results one edge after each request handshake.
// Backpressure: holds responses with rsp_ready low and checks payload stability.
module tb_hamming_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enc_valid, enc_ready;
  logic [10:0] enc_data;
  logic        dec_valid, dec_ready;
  logic [14:0] dec_cw;
  logic        enc_rsp_valid, enc_rsp_ready;
  logic [14:0] enc_rsp_cw;
  logic        dec_rsp_valid, dec_rsp_ready;
  logic [10:0] dec_rsp_data;
  logic [3:0]  dec_rsp_syn;
  logic        dec_rsp_corr;
  logic        err_clr;
  logic [7:0]  err_cnt;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_err = 8'h00;

`ifdef HAMMING_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  hamming_arb dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enc_valid     (enc_valid),
    .enc_ready     (enc_ready),
    .enc_data      (enc_data),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_cw        (dec_cw),
    .enc_rsp_valid (enc_rsp_valid),
    .enc_rsp_ready (enc_rsp_ready),
    .enc_rsp_cw    (enc_rsp_cw),
    .dec_rsp_valid (dec_rsp_valid),
    .dec_rsp_ready (dec_rsp_ready),
    .dec_rsp_data  (dec_rsp_data),
    .dec_rsp_syn   (dec_rsp_syn),
    .dec_rsp_corr  (dec_rsp_corr),
    .err_clr       (err_clr),
    .err_cnt       (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] err_exp();
    return CNT_EN ? exp_err : 8'h00;
  endfunction

  // Model of the corrected-word counter.
  task automatic err_model(input logic [3:0] syn, input bit clr);
    if (clr) exp_err = 8'h00;
    else if (syn != 4'd0 && exp_err != 8'hFF) exp_err = exp_err + 8'h01;
  endtask

  // Called just after a falling edge with valid raised; waits a bounded time for ready.
  task automatic wait_ready(input bit is_enc);
    int n = 0;
    #1;
    while (((is_enc ? enc_ready : dec_ready) !== 1'b1) && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
    chk(is_enc ? "enc_ready" : "dec_ready", is_enc ? enc_ready : dec_ready, 1);
    chk(is_enc ? "dec_ready_low" : "enc_ready_low", is_enc ? dec_ready : enc_ready, 0);
  endtask

  task automatic enc_op(input logic [10:0] d, input logic [14:0] exp_cw);
    enc_data  = d;
    enc_valid = 1'b1;
    wait_ready(1'b1);
    @(posedge clk); #1;
    enc_valid = 1'b0;
    chk("enc_rsp_valid", enc_rsp_valid, 1);
    chk("enc_rsp_cw", enc_rsp_cw, exp_cw);
    chk("enc_ready_busy", enc_ready, 0);
    @(negedge clk);
    enc_rsp_ready = 1'b1;
    @(posedge clk); #1;
    enc_rsp_ready = 1'b0;
    chk("enc_rsp_drop", enc_rsp_valid, 0);
    @(negedge clk);
  endtask

  task automatic dec_op(input logic [14:0] cw, input logic [10:0] ed, input logic [3:0] es,
                        input logic ec, input bit clr);
    dec_cw    = cw;
    dec_valid = 1'b1;
    err_clr   = clr;
    wait_ready(1'b0);
    @(posedge clk); #1;
    dec_valid = 1'b0;
    err_clr   = 1'b0;
    err_model(es, clr);
    chk("dec_rsp_valid", dec_rsp_valid, 1);
    chk("dec_rsp_data", dec_rsp_data, ed);
    chk("dec_rsp_syn", dec_rsp_syn, es);
    chk("dec_rsp_corr", dec_rsp_corr, ec);
    chk("err_cnt", err_cnt, err_exp());
    @(negedge clk);
    dec_rsp_ready = 1'b1;
    @(posedge clk); #1;
    dec_rsp_ready = 1'b0;
    chk("dec_rsp_drop", dec_rsp_valid, 0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    enc_valid = 1'b0; enc_data = '0; dec_valid = 1'b0; dec_cw = '0;
    enc_rsp_ready = 1'b0; dec_rsp_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_enc_rsp_valid", enc_rsp_valid, 0);
    chk("rst_dec_rsp_valid", dec_rsp_valid, 0);
    chk("rst_enc_ready", enc_ready, 0);
    chk("rst_dec_ready", dec_ready, 0);
    chk("rst_enc_rsp_cw", enc_rsp_cw, 0);
    chk("rst_dec_rsp_data", dec_rsp_data, 0);
    chk("rst_dec_rsp_syn", dec_rsp_syn, 0);
    chk("rst_dec_rsp_corr", dec_rsp_corr, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);

    // Encode vectors.
    enc_op(11'h000, 15'h0000);
    enc_op(11'h7FF, 15'h7FFF);
    enc_op(11'h555, 15'h552D);

    // Decode vectors: position-5 error, position-1 error, clean word.
    dec_op(15'h7FEF, 11'h7FF, 4'd5, 1'b1, 1'b0);
    dec_op(15'h0001, 11'h000, 4'd1, 1'b1, 1'b0);
    dec_op(15'h0000, 11'h000, 4'd0, 1'b0, 1'b0);
    dec_op(15'h552D, 11'h555, 4'd0, 1'b0, 1'b0);

    // Both channels requesting continuously: grants alternate, responses held 3 cycles.
    enc_data  = 11'h555;
    dec_cw    = 15'h0004;
    enc_valid = 1'b1;
    dec_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit is_enc;
      is_enc = (i % 2 == 0);
      #1;
      chk("alt_enc_ready", enc_ready, is_enc);
      chk("alt_dec_ready", dec_ready, !is_enc);
      @(posedge clk); #1;
      if (!is_enc) err_model(4'd3, 1'b0);
      for (int h = 0; h < 3; h++) begin
        chk("alt_ready_busy", enc_ready | dec_ready, 0);
        if (is_enc) begin
          chk("alt_enc_rsp_valid", enc_rsp_valid, 1);
          chk("alt_enc_rsp_cw", enc_rsp_cw, 15'h552D);
        end else begin
          chk("alt_dec_rsp_valid", dec_rsp_valid, 1);
          chk("alt_dec_rsp_data", dec_rsp_data, 11'h000);
          chk("alt_dec_rsp_syn", dec_rsp_syn, 4'd3);
          chk("alt_dec_rsp_corr", dec_rsp_corr, 1);
        end
        @(posedge clk); #1;
      end
      if (is_enc) enc_rsp_ready = 1'b1;
      else        dec_rsp_ready = 1'b1;
      @(posedge clk); #1;
      enc_rsp_ready = 1'b0;
      dec_rsp_ready = 1'b0;
      chk("alt_rsp_drop", enc_rsp_valid | dec_rsp_valid, 0);
      @(negedge clk);
    end
    enc_valid = 1'b0;
    dec_valid = 1'b0;
    chk("alt_err_cnt", err_cnt, err_exp());

    // Standalone clear.
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    err_model(4'd0, 1'b1);
    chk("clr_err_cnt", err_cnt, err_exp());
    @(negedge clk);

    // 256 erroneous decodes saturate the counter; clear beats a simultaneous 257th.
    for (int k = 0; k < 256; k++) dec_op(15'h0001, 11'h000, 4'd1, 1'b1, 1'b0);
    chk("sat_err_cnt", err_cnt, CNT_EN ? 8'hFF : 8'h00);
    dec_op(15'h0001, 11'h000, 4'd1, 1'b1, 1'b1);
    chk("clr_prio_err_cnt", err_cnt, 8'h00);

    // Reset while a decode response is pending.
    err_model(4'd1, 1'b0);
    dec_cw    = 15'h7FEF;
    dec_valid = 1'b1;
    wait_ready(1'b0);
    @(posedge clk); #1;
    dec_valid = 1'b0;
    chk("pre_rst_dec_rsp_valid", dec_rsp_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_err = 8'h00;
    chk("mid_rst_dec_rsp_valid", dec_rsp_valid, 0);
    chk("mid_rst_dec_rsp_data", dec_rsp_data, 0);
    chk("mid_rst_dec_rsp_syn", dec_rsp_syn, 0);
    chk("mid_rst_dec_rsp_corr", dec_rsp_corr, 0);
    chk("mid_rst_enc_rsp_valid", enc_rsp_valid, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_ready", enc_ready | dec_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // After reset, encode wins a tie.
    enc_data  = 11'h7FF;
    dec_cw    = 15'h0000;
    enc_valid = 1'b1;
    dec_valid = 1'b1;
    #1;
    chk("post_rst_enc_ready", enc_ready, 1);
    chk("post_rst_dec_ready", dec_ready, 0);
    @(posedge clk); #1;
    enc_valid = 1'b0;
    dec_valid = 1'b0;
    chk("post_rst_enc_rsp_valid", enc_rsp_valid, 1);
    chk("post_rst_enc_rsp_cw", enc_rsp_cw, 15'h7FFF);
    chk("post_rst_dec_rsp_valid", dec_rsp_valid, 0);
    @(negedge clk);
    enc_rsp_ready = 1'b1;
    @(posedge clk); #1;
    enc_rsp_ready = 1'b0;
    chk("post_rst_drop", enc_rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_arb.md
# hamming_arb

Shared Hamming(15,11) codec scheduler. Two requesters share one Hamming core: an encode channel (11-bit data in, 15-bit codeword out) and a decode channel (15-bit codeword in, corrected 11-bit data plus syndrome out). The block arbitrates round-robin, allows one operation in flight, registers each result, and holds it behind a valid/ready response handshake. It sits between the CPU datapath and protected storage and replaces the per-path encoder instances.

## Interface
- Parameters: none; widths are fixed by the (15,11) code.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- enc_valid  in  1  encode request present
- enc_ready  out  1  encode request accepted this cycle
- enc_data  in  11  data to encode
- dec_valid  in  1  decode request present
- dec_ready  out  1  decode request accepted this cycle
- dec_cw  in  15  codeword to check/correct
- enc_rsp_valid  out  1  encode result pending
- enc_rsp_ready  in  1  consumer takes encode result
- enc_rsp_cw  out  15  encoded codeword
- dec_rsp_valid  out  1  decode result pending
- dec_rsp_ready  in  1  consumer takes decode result
- dec_rsp_data  out  11  corrected data
- dec_rsp_syn  out  4  syndrome; 0 means no error
- dec_rsp_corr  out  1  a single-bit correction was applied
- err_clr  in  1  synchronous clear of err_cnt
- err_cnt  out  8  saturating count of corrected words

## Operation
- Code mapping: cw[i] is Hamming position i+1.
  - Parity bits sit at cw[0], cw[1], cw[3], cw[7].
  - d[0..10] fill cw[2], cw[4], cw[5], cw[6], cw[8..14] in ascending order.
  - Parity bit k is the XOR of all positions with bit k set.
- Decode: syndrome = XOR of the positions of all set bits.
  - A nonzero syndrome s flips cw[s-1], then data is extracted.
  - A double error miscorrects silently; this is accepted behaviour.
- FSM states: IDLE, ENC_RSP, DEC_RSP.
  - IDLE: enc_ready/dec_ready are asserted combinationally for the granted channel only.
  - IDLE, on handshake: latch the core result and go to ENC_RSP or DEC_RSP.
  - ENC_RSP/DEC_RSP: both ready outputs are low; the matching rsp_valid is high.
  - ENC_RSP/DEC_RSP, on rsp_valid&&rsp_ready: return to IDLE.
- Arbitration:
  - Only one channel valid: that channel is granted.
  - Both valid: grant goes to the channel not granted last.
  - last_grant resets to "dec", so enc wins the first tie.
  - last_grant updates only on an accepted request.
- Response payload registers hold their value while valid is high and the response is stalled.
- err_cnt:
  - Increments on the edge a decode request is accepted with a nonzero syndrome.
  - Saturates at 8'hFF.
  - err_clr takes priority over a simultaneous increment, so the result is 0.

## Timing
- Latency: request accepted at edge N, rsp_valid high from edge N to cycle N+1.
- Back-to-back: response accepted at edge M, next request accepted earliest at edge M+1. Peak throughput is 1 op per 2 cycles.
- Ready never depends on rsp_ready; there is no combinational path from response to request side.
- Reset values:
  - State: IDLE.
  - All ready/rsp_valid outputs: 0.
  - enc_rsp_cw, dec_rsp_data, dec_rsp_syn: 0.
  - dec_rsp_corr: 0.
  - err_cnt: 0.
  - last_grant: dec.
- Reset mid-operation: a pending response is dropped immediately; rsp_valid falls asynchronously.
- A request withdrawn before handshake is ignored, with no state change.

## Configuration
- HAMMING_ERRCNT_EN defined: err_cnt and err_clr behave as above.
- HAMMING_ERRCNT_EN undefined:
  - The counter logic is removed.
  - err_cnt is tied to 8'h00.
  - err_clr is ignored.
  - All other behaviour is identical.

## Structure
- hamming_pkg holds:
  - Width constants: DATA_W=11, CW_W=15, SYN_W=4.
  - Parity position constants.
  - State enum.
  - Grant enum.
- Sub-module hamming_core is purely combinational. It provides an 11-bit encode, plus a 15-bit syndrome/correct/extract. It is instantiated once and muxed by grant.

## Test plan
- enc_data=11'h000 -> enc_rsp_cw=15'h0000 one cycle after handshake. enc_data=11'h7FF -> 15'h7FFF.
- dec_cw=15'h7FEF (position 5 flipped) -> dec_rsp_data=11'h7FF, syn=4'd5, corr=1, err_cnt increments by 1.
- dec_cw=15'h0001 -> data=11'h000, syn=1, corr=1. dec_cw=15'h0000 -> syn=0, corr=0, err_cnt unchanged.
- enc_valid and dec_valid held high continuously -> grants alternate enc, dec, enc, dec; each response is held for 3 cycles with rsp_ready low and payload stable.
- 256 erroneous decodes, then err_clr asserted on the same edge as a 257th error -> err_cnt sticks at 8'hFF, then becomes 0.
- rst_n pulsed low while dec_rsp_valid=1 -> all outputs 0 immediately. After release, enc wins a simultaneous request.
